flex_counter_prog: RTL

Parametrised successor to the team's SPI flex counter, for SPI bit/byte sequencing and baud generation. Adds an integrated prescaler, up/down counting, synchronous load, a saturate mode, and separate level and pulse rollover indications. With prescale_val=0, count_down=0, saturate=0, load=0 and WRAP_TO_ONE=1, the count sequence (1..rollover_val, wrap to 1) is the same as the existing block.

---
 rtl/flex_counter_prog.sv | 124 ++++++++++++
 1 files changed

// File: rtl/flex_counter_prog.sv
// flex_counter_prog: prescaled up/down counter with load, saturate mode,
// a level rollover flag and a one-cycle rollover pulse. With prescale 0,
// counting up, no saturate and WRAP_TO_ONE=1 it counts 1..rollover_val.
module flex_counter_prog #(
    parameter int NUM_CNT_BITS  = 4,
    parameter int PRESCALE_BITS = 4,
    parameter bit WRAP_TO_ONE   = 1'b1
) (
    input  logic                      clk,
    input  logic                      n_rst,
    input  logic                      clear,
    input  logic                      load,
    input  logic                      count_enable,
    input  logic                      count_down,
    input  logic                      saturate,
    input  logic [NUM_CNT_BITS-1:0]   load_val,
    input  logic [NUM_CNT_BITS-1:0]   rollover_val,
    input  logic [PRESCALE_BITS-1:0]  prescale_val,
    output logic [NUM_CNT_BITS-1:0]   count_out,
    output logic                      rollover_flag,
    output logic                      rollover_pulse,
    output logic                      tick
);

    localparam logic [NUM_CNT_BITS-1:0]  START    = WRAP_TO_ONE ? NUM_CNT_BITS'(1) : '0;
    localparam logic [NUM_CNT_BITS-1:0]  CNT_ONE  = NUM_CNT_BITS'(1);
    localparam logic [PRESCALE_BITS-1:0] PRE_ONE  = PRESCALE_BITS'(1);

    logic [PRESCALE_BITS-1:0] prescaler;
    logic [PRESCALE_BITS-1:0] prescaler_next;
    logic [NUM_CNT_BITS-1:0]  start_eff;
    logic [NUM_CNT_BITS-1:0]  terminal;
    logic [NUM_CNT_BITS-1:0]  count_inc;
    logic [NUM_CNT_BITS-1:0]  count_dec;
    logic [NUM_CNT_BITS-1:0]  stepped_count;
    logic [NUM_CNT_BITS-1:0]  count_next;
    logic                     step_pulse;
    logic                     pulse_next;
    logic                     tick_next;
    logic                     flag_next;

    // Wrap start clipped to rollover_val, and the terminal for the current direction.
    always_comb begin
        start_eff = (START < rollover_val) ? START : rollover_val;
        terminal  = count_down ? start_eff : rollover_val;
        count_inc = count_out + CNT_ONE;
        count_dec = count_out - CNT_ONE;
    end

    // Value the count would take if a step happens now, and whether that step pulses.
    always_comb begin
        stepped_count = count_out;
        step_pulse    = 1'b0;
        if (!count_down) begin
            if (count_out == rollover_val) begin
                if (!saturate) begin
                    stepped_count = start_eff;
                    step_pulse    = 1'b1;
                end
            end else if (count_out > rollover_val) begin
                stepped_count = start_eff;
                step_pulse    = 1'b1;
            end else begin
                stepped_count = count_inc;
                step_pulse    = saturate && (count_inc == rollover_val);
            end
        end else begin
            if (count_out <= start_eff) begin
                if (!saturate) begin
                    stepped_count = rollover_val;
                    step_pulse    = 1'b1;
                end
            end else if (count_out > rollover_val) begin
                stepped_count = rollover_val;
            end else begin
                stepped_count = count_dec;
                step_pulse    = saturate && (count_dec == start_eff);
            end
        end
    end

    // Clear beats load beats a prescaled step; otherwise everything holds.
    always_comb begin
        count_next     = count_out;
        prescaler_next = prescaler;
        pulse_next     = 1'b0;
        tick_next      = 1'b0;
        if (clear) begin
            count_next     = '0;
            prescaler_next = '0;
        end else if (load) begin
            count_next     = load_val;
            prescaler_next = '0;
        end else if (count_enable) begin
            if (prescaler == prescale_val) begin
                prescaler_next = '0;
                count_next     = stepped_count;
                pulse_next     = step_pulse;
                tick_next      = 1'b1;
            end else begin
                prescaler_next = prescaler + PRE_ONE;
            end
        end
        flag_next = !clear && (count_next == terminal);
    end

    // Output and prescaler registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_out      <= '0;
            prescaler      <= '0;
            rollover_flag  <= 1'b0;
            rollover_pulse <= 1'b0;
            tick           <= 1'b0;
        end else begin
            count_out      <= count_next;
            prescaler      <= prescaler_next;
            rollover_flag  <= flag_next;
            rollover_pulse <= pulse_next;
            tick           <= tick_next;
        end
    end

endmodule
